grey_init_loader: RTL and testbench

- Serial configuration controller for the 12-digit grey counter.
- The counter's 60-bit preload word (12 digits x 5 bits) cannot reach the chip through the 8-pin input bus, so this block assembles it from a serial frame.
- It holds the counter frozen while a frame is in flight, then presents the completed word with a one-cycle LOAD strobe.
- It sits between the io_in pins and the counter's init/load inputs.

---
 rtl/grey_pkg.sv | 14 +
 rtl/grey_init_loader_if.sv | 24 ++
 rtl/grey_gap_timer.sv | 29 ++
 rtl/grey_init_loader.sv | 112 +++++++++++
 tb/tb_grey_init_loader.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/grey_pkg.sv
// rtl/grey_pkg.sv - shared widths and state encoding for the grey counter and its init loader
package grey_pkg;

    localparam int NDIG   = 12;
    localparam int DIG_W  = 5;
    localparam int INIT_W = NDIG * DIG_W;
    localparam int BITS_W = $clog2(INIT_W);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

endpackage

// File: rtl/grey_init_loader_if.sv
// rtl/grey_init_loader_if.sv - serial frame input and preload output bundle of the init loader
interface grey_init_loader_if;
    import grey_pkg::*;

    logic              START;
    logic              DIN;
    logic              DVALID;
    logic [INIT_W-1:0] INIT;
    logic              LOAD;
    logic              BUSY;
    logic              ERR;
    logic [BITS_W-1:0] BITS;

    modport master (
        output START, DIN, DVALID,
        input  INIT, LOAD, BUSY, ERR, BITS
    );

    modport slave (
        input  START, DIN, DVALID,
        output INIT, LOAD, BUSY, ERR, BITS
    );

endinterface

// File: rtl/grey_gap_timer.sv
// rtl/grey_gap_timer.sv - saturating idle-gap counter; pulses expired on the TIMEOUT-th idle tick
module grey_gap_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            cnt <= '0;
        end else if (tick && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Fires on the tick that would bring the count up to TIMEOUT.
    assign expired = (TIMEOUT != 0) && tick && (cnt == CNT_LAST);

endmodule

// File: rtl/grey_init_loader.sv
// rtl/grey_init_loader.sv - assembles the 60-bit grey counter preload word from a serial frame
module grey_init_loader
    import grey_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RST,
    grey_init_loader_if.slave   bus
);

    state_t              state, state_n;
    logic [INIT_W-2:0]   sr, sr_n;
    logic [BITS_W-1:0]   bits, bits_n;
    logic [INIT_W-1:0]   init_q, init_n;
    logic                load_q, load_n;
    logic                busy_q, busy_n;
    logic                err_q, err_n;
    logic                gap_clr;
    logic                gap_tick;
    logic                gap_expired;

    grey_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (gap_clr),
        .tick    (gap_tick),
        .expired (gap_expired)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            sr     <= '0;
            bits   <= '0;
            init_q <= '0;
            load_q <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            sr     <= sr_n;
            bits   <= bits_n;
            init_q <= init_n;
            load_q <= load_n;
            busy_q <= busy_n;
            err_q  <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        sr_n     = sr;
        bits_n   = bits;
        init_n   = init_q;
        load_n   = 1'b0;
        busy_n   = busy_q;
        err_n    = err_q;
        gap_clr  = 1'b0;
        gap_tick = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (bus.START) begin
                    state_n = ST_SHIFT;
                    busy_n  = 1'b1;
                    bits_n  = '0;
                    sr_n    = '0;
                    err_n   = 1'b0;
                    gap_clr = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bus.START) begin
                    bits_n  = '0;
                    sr_n    = '0;
                    gap_clr = 1'b1;
                end else if (bus.DVALID) begin
                    sr_n    = {sr[INIT_W-3:0], bus.DIN};
                    gap_clr = 1'b1;
                    if (bits == BITS_W'(INIT_W - 1)) begin
                        // Only a complete frame ever reaches the shadow INIT register.
                        init_n  = {sr, bus.DIN};
                        load_n  = 1'b1;
                        busy_n  = 1'b0;
                        bits_n  = '0;
                        state_n = ST_IDLE;
                    end else begin
                        bits_n = bits + BITS_W'(1);
                    end
                end else begin
                    gap_tick = 1'b1;
                    if (gap_expired) begin
                        state_n = ST_IDLE;
                        busy_n  = 1'b0;
                        err_n   = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.INIT = init_q;
    assign bus.LOAD = load_q;
    assign bus.BUSY = busy_q;
    assign bus.ERR  = err_q;
    assign bus.BITS = bits;

endmodule

// File: tb/tb_grey_init_loader.sv
// tb/tb_grey_init_loader.sv - directed self-checking bench for grey_init_loader
module tb_grey_init_loader;
    import grey_pkg::*;

    localparam logic [INIT_W-1:0] W_A  = 60'h123456789ABCDEF;
    localparam logic [INIT_W-1:0] W_B  = 60'hFEDCBA987654321;
    localparam logic [INIT_W-1:0] W_AA = 60'h0000000000000AA;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    grey_init_loader_if bus ();

    grey_init_loader #(
        .TIMEOUT (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int busy_cnt;
    int load_cnt;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_word(input logic [INIT_W-1:0] w, input int gap);
        busy_cnt = 0;
        load_cnt = 0;
        for (int i = INIT_W - 1; i >= 0; i--) begin
            bus.DIN    = w[i];
            bus.DVALID = 1'b1;
            step();
            if (bus.BUSY) busy_cnt++;
            if (bus.LOAD) load_cnt++;
            bus.DVALID = 1'b0;
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    step();
                    if (bus.BUSY) busy_cnt++;
                    if (bus.LOAD) load_cnt++;
                end
            end
        end
    endtask

    task automatic send_ones(input int n);
        for (int i = 0; i < n; i++) begin
            bus.DIN    = 1'b1;
            bus.DVALID = 1'b1;
            step();
        end
        bus.DVALID = 1'b0;
    endtask

    task automatic start_pulse();
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
    endtask

    task automatic test_reset();
        RST        = 1'b1;
        bus.START  = 1'b1;
        bus.DVALID = 1'b1;
        bus.DIN    = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({bus.INIT, bus.LOAD, bus.BUSY, bus.ERR, bus.BITS} !== '0) begin
                errors++;
                $display("FAIL reset cycle %0d: init=%h load=%b busy=%b err=%b bits=%0d, want all zero",
                         c, bus.INIT, bus.LOAD, bus.BUSY, bus.ERR, bus.BITS);
            end
        end
        RST        = 1'b0;
        bus.START  = 1'b0;
        bus.DVALID = 1'b0;
        bus.DIN    = 1'b0;
        step();
    endtask

    task automatic test_full_frame();
        start_pulse();
        checks++;
        if (bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL full_busy_entry: busy=%b want 1", bus.BUSY);
        end
        send_word(W_A, 0);
        checks++;
        if (busy_cnt + 1 !== 60) begin
            errors++;
            $display("FAIL full_busy_cycles: got %0d want 60", busy_cnt + 1);
        end
        checks++;
        if (bus.LOAD !== 1'b1 || bus.INIT !== W_A || bus.BUSY !== 1'b0 || bus.ERR !== 1'b0) begin
            errors++;
            $display("FAIL full_complete: load=%b init=%h busy=%b err=%b want 1 %h 0 0",
                     bus.LOAD, bus.INIT, bus.BUSY, bus.ERR, W_A);
        end
        step();
        checks++;
        if (bus.LOAD !== 1'b0 || load_cnt !== 1) begin
            errors++;
            $display("FAIL full_load_width: load=%b during=%0d want 0 and 1", bus.LOAD, load_cnt);
        end
    endtask

    task automatic test_gapped_and_timeout();
        start_pulse();
        send_word(W_B, 3);
        checks++;
        if (busy_cnt !== 59 + 59 * 3 || load_cnt !== 1 || bus.INIT !== W_B) begin
            errors++;
            $display("FAIL gapped_frame: busy=%0d load=%0d init=%h want 236 1 %h",
                     busy_cnt, load_cnt, bus.INIT, W_B);
        end
        step();
        start_pulse();
        send_ones(20);
        checks++;
        if (bus.BITS !== 6'd20) begin
            errors++;
            $display("FAIL timeout_bits: got %0d want 20", bus.BITS);
        end
        load_cnt = 0;
        for (int g = 0; g < 3; g++) begin
            step();
            if (bus.LOAD) load_cnt++;
        end
        checks++;
        if (bus.BUSY !== 1'b1 || bus.ERR !== 1'b0) begin
            errors++;
            $display("FAIL gap3_alive: busy=%b err=%b want 1 0", bus.BUSY, bus.ERR);
        end
        step();
        if (bus.LOAD) load_cnt++;
        checks++;
        if (bus.BUSY !== 1'b0 || bus.ERR !== 1'b1 || load_cnt !== 0 || bus.INIT !== W_B) begin
            errors++;
            $display("FAIL timeout_abort: busy=%b err=%b loads=%0d init=%h want 0 1 0 %h",
                     bus.BUSY, bus.ERR, load_cnt, bus.INIT, W_B);
        end
    endtask

    task automatic test_restart();
        start_pulse();
        checks++;
        if (bus.ERR !== 1'b0 || bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL restart_err_clear: err=%b busy=%b want 0 1", bus.ERR, bus.BUSY);
        end
        send_ones(30);
        checks++;
        if (bus.BITS !== 6'd30) begin
            errors++;
            $display("FAIL restart_bits30: got %0d want 30", bus.BITS);
        end
        start_pulse();
        checks++;
        if (bus.BITS !== 6'd0 || bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL restart_bits0: bits=%0d busy=%b want 0 1", bus.BITS, bus.BUSY);
        end
        send_word(W_AA, 0);
        checks++;
        if (bus.INIT !== W_AA || load_cnt !== 1) begin
            errors++;
            $display("FAIL restart_frame: init=%h loads=%0d want %h 1", bus.INIT, load_cnt, W_AA);
        end
        step();
    endtask

    task automatic test_collisions();
        bus.START  = 1'b1;
        bus.DVALID = 1'b1;
        bus.DIN    = 1'b1;
        step();
        bus.START  = 1'b0;
        bus.DVALID = 1'b0;
        checks++;
        if (bus.BITS !== 6'd0 || bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL idle_start_dvalid: bits=%0d busy=%b want 0 1", bus.BITS, bus.BUSY);
        end
        send_ones(59);
        checks++;
        if (bus.BITS !== 6'd59) begin
            errors++;
            $display("FAIL bits59: got %0d want 59", bus.BITS);
        end
        bus.START  = 1'b1;
        bus.DVALID = 1'b1;
        step();
        bus.START  = 1'b0;
        bus.DVALID = 1'b0;
        checks++;
        if (bus.LOAD !== 1'b0 || bus.BITS !== 6'd0 || bus.BUSY !== 1'b1 || bus.INIT !== W_AA) begin
            errors++;
            $display("FAIL start_with_60th: load=%b bits=%0d busy=%b init=%h want 0 0 1 %h",
                     bus.LOAD, bus.BITS, bus.BUSY, bus.INIT, W_AA);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_ones(45);
        checks++;
        if (bus.BITS !== 6'd45) begin
            errors++;
            $display("FAIL mid_bits45: got %0d want 45", bus.BITS);
        end
        RST = 1'b1;
        step();
        RST = 1'b0;
        checks++;
        if (bus.BUSY !== 1'b0 || bus.INIT !== '0 || bus.BITS !== 6'd0 || bus.LOAD !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b init=%h bits=%0d load=%b want 0 0 0 0",
                     bus.BUSY, bus.INIT, bus.BITS, bus.LOAD);
        end
        start_pulse();
        send_word(W_A, 0);
        checks++;
        if (bus.INIT !== W_A || load_cnt !== 1 || bus.LOAD !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_frame: init=%h loads=%0d want %h 1", bus.INIT, load_cnt, W_A);
        end
    endtask

    task automatic test_back_to_back();
        start_pulse();
        checks++;
        if (bus.LOAD !== 1'b0 || bus.BUSY !== 1'b1 || bus.INIT !== W_A) begin
            errors++;
            $display("FAIL b2b_entry: load=%b busy=%b init=%h want 0 1 %h",
                     bus.LOAD, bus.BUSY, bus.INIT, W_A);
        end
        send_word(W_B, 0);
        checks++;
        if (bus.INIT !== W_B || load_cnt !== 1 || busy_cnt !== 59) begin
            errors++;
            $display("FAIL b2b_frame: init=%h loads=%0d busy=%0d want %h 1 59",
                     bus.INIT, load_cnt, busy_cnt, W_B);
        end
        step();
    endtask

    initial begin
        RST        = 1'b1;
        bus.START  = 1'b0;
        bus.DIN    = 1'b0;
        bus.DVALID = 1'b0;
        test_reset();
        test_full_frame();
        test_gapped_and_timeout();
        test_restart();
        test_collisions();
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
